// File: rtl/pipereg_skid_if.sv
// Handshake bundle between an upstream stage, the pipereg_skid stage and its downstream consumer.
// valid/ready: an entry moves when valid & ready are both high at a rising edge; valid and its payload hold until then.
interface pipereg_skid_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  // Environment side: feeds entries in, drains them out.
  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy
  );

  // Stage side.
  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy
  );
endinterface

// File: rtl/pipereg_skid.sv
// Two-entry pipeline register: a head entry driving the outputs plus a skid entry that absorbs
// one extra input so in_ready depends only on registered state.
module pipereg_skid #(
  parameter int DATA_W   = 32,
  parameter int CTRL_W   = 24,
  parameter bit CLR_DATA = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  pipereg_skid_if.slave  bus
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  logic in_fire;
  logic out_fire;

  assign bus.in_ready  = !skid_valid;
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = main_valid & bus.out_ready;

  // A bubble always carries an all-zero control word so downstream treats it as a no-op.
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data;
  assign bus.out_ctrl  = main_valid ? main_ctrl : '0;
  assign bus.occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
      if (CLR_DATA) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else if (!main_valid) begin
      // Skid is never occupied while main is empty, so input goes straight to the head.
      if (in_fire) begin
        main_valid <= 1'b1;
        main_data  <= bus.in_data;
        main_ctrl  <= bus.in_ctrl;
      end
    end else if (out_fire) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        main_ctrl  <= skid_ctrl;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        main_data <= bus.in_data;
        main_ctrl <= bus.in_ctrl;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= bus.in_data;
      skid_ctrl  <= bus.in_ctrl;
    end
  end

endmodule

// File: tb/tb_pipereg_skid.sv
// Bench for pipereg_skid: directed scenarios plus a long random run, scored against an
// ordered queue of accepted entries.
module tb_pipereg_skid;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 24;
  localparam int W      = DATA_W + CTRL_W;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic flush_nc;

  pipereg_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();
  pipereg_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus_nc ();

  pipereg_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLR_DATA(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );

  pipereg_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLR_DATA(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .flush(flush_nc), .bus(bus_nc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;

  logic [W-1:0] exp_q[$];
  logic         pend_push = 1'b0;
  logic [W-1:0] pend_item;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                        input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.out_ready = r;
  endtask

  // Monitor: compares the DUT against the model queue, then retires what leaves this edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pend_push = 1'b0;
    end else begin
      check("occupancy", 64'(bus.occupancy), 64'(exp_q.size()));
      check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
      check("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2));
      if (exp_q.size() > 0) begin
        check("out_data", 64'(bus.out_data), 64'(exp_q[0][DATA_W-1:0]));
        check("out_ctrl", 64'(bus.out_ctrl), 64'(exp_q[0][W-1:DATA_W]));
      end else begin
        check("bubble_ctrl", 64'(bus.out_ctrl), 64'd0);
      end
      if (flush) begin
        exp_q.delete();
      end else if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_out++;
      end
      pend_push = !flush && bus.in_valid && bus.in_ready;
      pend_item = {bus.in_ctrl, bus.in_data};
    end
  end

  // Entries accepted in a cycle join the model at the edge that captures them.
  always @(posedge clk) begin
    if (pend_push) exp_q.push_back(pend_item);
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    flush_nc = 1'b0;
    set_in(1'b0, '0, '0, 1'b0);
    bus_nc.in_valid = 1'b0;
    bus_nc.in_data = '0;
    bus_nc.in_ctrl = '0;
    bus_nc.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values on both variants.
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    check("rst_occupancy", 64'(bus.occupancy), 64'd0);
    check("rst_nc_out_data", 64'(bus_nc.out_data), 64'd0);
    check("rst_nc_in_ready", 64'(bus_nc.in_ready), 64'd1);

    // Streaming 1,2,3,4 with latency 1 and continuous valid.
    for (int i = 1; i <= 4; i++) begin
      tick();
      set_in(1'b1, DATA_W'(i), CTRL_W'(24'h10 + i), 1'b1);
      @(negedge clk);
      if (i > 1) begin
        check("stream_data", 64'(bus.out_data), 64'(i - 1));
        check("stream_valid", 64'(bus.out_valid), 64'd1);
        check("stream_occ", 64'(bus.occupancy), 64'd1);
      end
    end
    tick();
    set_in(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    check("stream_last", 64'(bus.out_data), 64'd4);
    tick();
    @(negedge clk);
    check("stream_empty", 64'(bus.out_valid), 64'd0);

    // Backpressure: A then B held, released in order.
    tick();
    set_in(1'b1, 32'hAAAA0001, 24'h0000A1, 1'b0);
    tick();
    set_in(1'b1, 32'hBBBB0002, 24'h0000B2, 1'b0);
    tick();
    set_in(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    check("bp_occ", 64'(bus.occupancy), 64'd2);
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_head", 64'(bus.out_data), 64'hAAAA0001);
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_head_hold", 64'(bus.out_data), 64'hAAAA0001);
    @(negedge clk);
    check("bp_second", 64'(bus.out_data), 64'hBBBB0002);
    check("bp_in_ready_back", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    check("bp_drained", 64'(bus.occupancy), 64'd0);

    // Flush while full, with an input offered the same cycle.
    tick();
    set_in(1'b1, 32'h11110001, 24'h000C01, 1'b0);
    tick();
    set_in(1'b1, 32'h11110002, 24'h000C02, 1'b0);
    tick();
    set_in(1'b1, 32'h11110003, 24'h000C03, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_in(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    check("flush_ctrl", 64'(bus.out_ctrl), 64'd0);
    check("flush_occ", 64'(bus.occupancy), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    check("flush_data_clr", 64'(bus.out_data), 64'd0);

    // Flush with one entry while both in_fire and out_fire happen.
    tick();
    set_in(1'b1, 32'h22220001, 24'h000D01, 1'b0);
    tick();
    set_in(1'b1, 32'h22220002, 24'h000D02, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_in(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    check("flush1_occ", 64'(bus.occupancy), 64'd0);
    check("flush1_valid", 64'(bus.out_valid), 64'd0);
    tick();
    @(negedge clk);
    check("flush1_stays_empty", 64'(bus.occupancy), 64'd0);

    // Data-preserving variant keeps the payload across flush.
    tick();
    bus_nc.in_valid = 1'b1;
    bus_nc.in_data = 32'hDEADBEEF;
    bus_nc.in_ctrl = 24'hABCDEF;
    tick();
    bus_nc.in_valid = 1'b0;
    @(negedge clk);
    check("nc_loaded_data", 64'(bus_nc.out_data), 64'hDEADBEEF);
    check("nc_loaded_ctrl", 64'(bus_nc.out_ctrl), 64'hABCDEF);
    tick();
    flush_nc = 1'b1;
    tick();
    flush_nc = 1'b0;
    @(negedge clk);
    check("nc_flush_data", 64'(bus_nc.out_data), 64'hDEADBEEF);
    check("nc_flush_ctrl", 64'(bus_nc.out_ctrl), 64'd0);
    check("nc_flush_valid", 64'(bus_nc.out_valid), 64'd0);
    check("nc_flush_occ", 64'(bus_nc.occupancy), 64'd0);

    // Reset and flush together while full; reset also clears the data-preserving variant.
    tick();
    set_in(1'b1, 32'h33330001, 24'hFFFFFF, 1'b0);
    tick();
    set_in(1'b1, 32'h33330002, 24'hFFFFFF, 1'b0);
    tick();
    rst = 1'b1;
    flush = 1'b1;
    set_in(1'b1, 32'h33330003, 24'hFFFFFF, 1'b1);
    tick();
    rst = 1'b0;
    flush = 1'b0;
    set_in(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    check("rf_in_ready", 64'(bus.in_ready), 64'd1);
    check("rf_out_valid", 64'(bus.out_valid), 64'd0);
    check("rf_out_data", 64'(bus.out_data), 64'd0);
    check("rf_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    check("rf_occ", 64'(bus.occupancy), 64'd0);
    check("rf_nc_out_data", 64'(bus_nc.out_data), 64'd0);

    // Random traffic against the queue model.
    for (int c = 0; c < 10000; c++) begin
      tick();
      set_in(1'($urandom_range(0, 99) < 60), DATA_W'($urandom), CTRL_W'($urandom),
             1'($urandom_range(0, 99) < 50));
      flush = 1'($urandom_range(0, 99) < 1);
    end
    tick();
    flush = 1'b0;
    set_in(1'b0, '0, '0, 1'b1);
    repeat (4) tick();
    @(negedge clk);
    check("drained_model", 64'(exp_q.size()), 64'd0);
    check("outputs_seen", 64'(n_out > 1000), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipereg_skid.md
PIPEREG_SKID -- requirements
Module: pipereg_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the datapath payload (operands, immediates, PCs).
REQ-002 SHALL have parameter CTRL_W, default 24: width of the control payload (ALU op, write enable, select fields).
REQ-003 SHALL have parameter CLR_DATA, default 1: 1 = data payload zeroed on reset/flush; 0 = data payload held, only control zeroed.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-006 SHALL have port flush, input, 1: synchronous kill of all held entries.
REQ-007 SHALL have port in_valid, input, 1: upstream stage presents an entry.
REQ-008 SHALL have port in_ready, output, 1: stage can accept an entry this cycle.
REQ-009 SHALL have port in_data, input, DATA_W: upstream data payload.
REQ-010 SHALL have port in_ctrl, input, CTRL_W: upstream control payload.
REQ-011 SHALL have port out_valid, output, 1: stage presents an entry downstream.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts this cycle.
REQ-013 SHALL have port out_data, output, DATA_W: head entry data payload.
REQ-014 SHALL have port out_ctrl, output, CTRL_W: head entry control payload.
REQ-015 SHALL have port occupancy, output, 2: number of held entries (0..2).

Function
REQ-016 SHALL hold two entries: main (head, drives outputs) and skid (overflow); each has a valid bit.
REQ-017 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-018 SHALL drive in_ready = !skid_valid from registered state only; no combinational path from out_ready to in_ready.
REQ-019 SHALL drive out_valid = main_valid, out_data = main data, occupancy = main_valid + skid_valid.
REQ-020 SHALL force out_ctrl to all-zero whenever out_valid = 0, so a bubble is a no-op.
REQ-021 Main empty, in_fire: SHALL load input into main; out_valid next cycle (latency 1).
REQ-022 Main full, out_fire, skid empty, in_fire: SHALL load input into main (throughput 1 entry/cycle).
REQ-023 Main full, out_fire, skid full: SHALL move skid into main and clear skid (in_ready is 0, no input accepted).
REQ-024 Main full, no out_fire, in_fire: SHALL store input in skid.
REQ-025 Main full, no out_fire, no in_fire: SHALL hold all state unchanged (stall).
REQ-026 SHALL preserve entry order; no entry duplicated or dropped absent flush.
REQ-027 flush: SHALL clear main_valid and skid_valid, zero both control payloads, zero both data payloads when CLR_DATA = 1, next edge.
REQ-028 flush: SHALL discard any in_fire and out_fire in the same cycle (flush wins); in_ready = 1 the following cycle.
REQ-029 SHALL not allow in_valid = 1 with in_ready = 0 to alter state.

Reset
REQ-030 rst = 1 at a rising edge: SHALL clear both valid bits, zero all control payloads, zero all data payloads regardless of CLR_DATA.
REQ-031 Post-reset outputs SHALL be: in_ready = 1, out_valid = 0, out_data = 0, out_ctrl = 0, occupancy = 0.
REQ-032 rst SHALL take priority over flush and any handshake in the same cycle, including mid-operation with both entries full.

Verification
REQ-033 Streaming: out_ready = 1, in_valid = 1 with in_data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each, out_valid continuous, occupancy = 1.
REQ-034 Backpressure: send A, B with out_ready = 0 -> occupancy 2, in_ready = 0, out_data = A; raise out_ready -> A then B, in_ready = 1 after A leaves.
REQ-035 Flush with occupancy 2 and in_fire same cycle -> next cycle out_valid = 0, out_ctrl = 0, occupancy = 0, in_ready = 1; input entry absent downstream.
REQ-036 CLR_DATA = 0, flush with out_data = 0xDEADBEEF -> out_data stays 0xDEADBEEF, out_ctrl = 0, out_valid = 0.
REQ-037 rst and flush asserted together while full, in_ctrl = 0xFFFFFF -> all outputs at REQ-031 values next cycle.
REQ-038 Random in_valid/out_ready (10k cycles) vs reference queue model -> order preserved, no loss, occupancy never > 2, out_ctrl = 0 whenever out_valid = 0.
